// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, unit-select encodings, sequencer states and the
//            opcode-to-unit decode used by the ALU sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_INC   = 4'b0010;
    localparam logic [3:0] OP_DEC   = 4'b0011;
    localparam logic [3:0] OP_PASS  = 4'b0100;
    localparam logic [3:0] OP_NEG   = 4'b0101;
    localparam logic [3:0] A_AND_B  = 4'b0110;
    localparam logic [3:0] A_OR_B   = 4'b0111;
    localparam logic [3:0] A_XOR_B  = 4'b1000;
    localparam logic [3:0] A_NAND_B = 4'b1001;
    localparam logic [3:0] A_NOR_B  = 4'b1010;
    localparam logic [3:0] A_XNOR_B = 4'b1011;
    localparam logic [3:0] OP_SHL   = 4'b1100;
    localparam logic [3:0] OP_SHR   = 4'b1101;
    localparam logic [3:0] OP_ROL   = 4'b1110;
    localparam logic [3:0] OP_ROR   = 4'b1111;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_ARITH = 3'b001;
    localparam logic [2:0] SEL_GATE  = 3'b010;
    localparam logic [2:0] SEL_SHIFT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [2:0] decode_sel(input logic [3:0] op);
        if (op <= OP_NEG)
            return SEL_ARITH;
        else if (op <= A_XNOR_B)
            return SEL_GATE;
        else
            return SEL_SHIFT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_arb.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter; the pointer moves past the winner
//            only when a grant is actually accepted.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] ready,
    output logic       grant_id,
    output logic       accept
);

    logic ptr;

    always_comb begin
        ready = 2'b00;
        if (enable) begin
            if (valid[ptr])
                ready[ptr] = 1'b1;
            else if (valid[~ptr])
                ready[~ptr] = 1'b1;
        end
    end

    assign grant_id = ready[1];
    assign accept   = |(valid & ready);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (accept)
            ptr <= ~grant_id;
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Shares the arith/gate/shift units between two requesters and
//            returns a tagged response after the fixed unit latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_pkg::*;
#(
    parameter int UNIT_LATENCY = 1,
    parameter int NUM_REQ      = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_REQ-1:0]      Req_Valid,
    output logic [NUM_REQ-1:0]      Req_Ready,
    input  logic [NUM_REQ-1:0][3:0] Req_Opcode,
    input  logic [NUM_REQ-1:0][7:0] Req_A,
    input  logic [NUM_REQ-1:0][7:0] Req_B,
    output logic [3:0]              Opcode,
    output logic [7:0]              A,
    output logic [7:0]              B,
    output logic [2:0]              Select,
    input  logic [7:0]              Arith_Result,
    input  logic [7:0]              Gate_Result,
    input  logic [7:0]              Shift_Result,
    input  logic                    Arith_Flag,
    input  logic                    Gate_Flag,
    input  logic                    Shift_Flag,
    output logic                    Rsp_Valid,
    input  logic                    Rsp_Ready,
    output logic [7:0]              Rsp_Result,
    output logic                    Rsp_Error,
    output logic                    Rsp_Id,
    output logic                    Busy
);

    state_t     state, state_next;
    logic [2:0] cnt;
    logic       grant_id;
    logic       accept;
    logic [7:0] unit_result;
    logic       unit_flag;

    rr_arbiter2 u_arb (
        .clk      (Clk),
        .rst      (Reset),
        .enable   (state == IDLE),
        .valid    (Req_Valid),
        .ready    (Req_Ready),
        .grant_id (grant_id),
        .accept   (accept)
    );

    // Only the unit being driven may contribute; other units' flags are stale.
    always_comb begin
        unit_result = 8'h00;
        unit_flag   = 1'b0;
        case (Select)
            SEL_ARITH: begin unit_result = Arith_Result; unit_flag = Arith_Flag; end
            SEL_GATE:  begin unit_result = Gate_Result;  unit_flag = Gate_Flag;  end
            SEL_SHIFT: begin unit_result = Shift_Result; unit_flag = Shift_Flag; end
            default:   begin unit_result = 8'h00;        unit_flag = 1'b0;       end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)        state_next = EXEC;
            EXEC:    if (cnt == 3'd0)   state_next = RESP;
            RESP:    if (Rsp_Ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Opcode     <= 4'h0;
            A          <= 8'h00;
            B          <= 8'h00;
            Select     <= SEL_NONE;
            cnt        <= 3'd0;
            Rsp_Valid  <= 1'b0;
            Rsp_Result <= 8'h00;
            Rsp_Error  <= 1'b0;
            Rsp_Id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        Opcode <= Req_Opcode[grant_id];
                        A      <= Req_A[grant_id];
                        B      <= Req_B[grant_id];
                        Select <= decode_sel(Req_Opcode[grant_id]);
                        Rsp_Id <= grant_id;
                        cnt    <= 3'(UNIT_LATENCY);
                    end
                end
                EXEC: begin
                    if (cnt == 3'd0) begin
                        Select     <= SEL_NONE;
                        Rsp_Valid  <= 1'b1;
                        Rsp_Result <= unit_flag ? unit_result : 8'h00;
                        Rsp_Error  <= ~unit_flag;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (Rsp_Ready)
                        Rsp_Valid <= 1'b0;
                end
                default: begin
                    Select    <= SEL_NONE;
                    Rsp_Valid <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with behavioural units and
//            a response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [1:0]      Req_Valid = 2'b00;
    logic [1:0]      Req_Ready;
    logic [1:0][3:0] Req_Opcode = '0;
    logic [1:0][7:0] Req_A = '0;
    logic [1:0][7:0] Req_B = '0;
    logic [3:0]      Opcode;
    logic [7:0]      A, B;
    logic [2:0]      Select;
    logic [7:0]      arith_res = 8'h00, gate_res = 8'h00, shift_res = 8'h00;
    logic            arith_flag = 1'b0, gate_flag = 1'b0, shift_flag = 1'b0;
    logic            Rsp_Valid;
    logic            Rsp_Ready = 1'b1;
    logic [7:0]      Rsp_Result;
    logic            Rsp_Error;
    logic            Rsp_Id;
    logic            Busy;
    logic            err_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } rsp_t;
    rsp_t sb[$];

    always #5 Clk = ~Clk;

    alu_sequencer #(.UNIT_LATENCY(1), .NUM_REQ(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_Opcode(Req_Opcode), .Req_A(Req_A), .Req_B(Req_B),
        .Opcode(Opcode), .A(A), .B(B), .Select(Select),
        .Arith_Result(arith_res), .Gate_Result(gate_res), .Shift_Result(shift_res),
        .Arith_Flag(arith_flag), .Gate_Flag(gate_flag), .Shift_Flag(shift_flag),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Result(Rsp_Result),
        .Rsp_Error(Rsp_Error), .Rsp_Id(Rsp_Id), .Busy(Busy)
    );

    function automatic logic [7:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a + 8'd1;
            4'h3: return a - 8'd1;
            4'h4: return a;
            4'h5: return -a;
            4'h6: return a & b;
            4'h7: return a | b;
            4'h8: return a ^ b;
            4'h9: return ~(a & b);
            4'hA: return ~(a | b);
            4'hB: return ~(a ^ b);
            4'hC: return {a[6:0], 1'b0};
            4'hD: return {1'b0, a[7:1]};
            4'hE: return {a[6:0], a[7]};
            default: return {a[0], a[7:1]};
        endcase
    endfunction

    function automatic rsp_t mk(input logic id, input logic [7:0] r, input logic e);
        return {id, r, e};
    endfunction

    // Latency-1 unit models; flags are sticky so stale flags stay high.
    always @(posedge Clk) begin
        if (Select[0]) begin arith_res <= model(Opcode, A, B); arith_flag <= 1'b1; end
        if (Select[1]) begin gate_res  <= model(Opcode, A, B); gate_flag  <= 1'b1; end
        if (Select[2]) begin
            shift_res  <= model(Opcode, A, B);
            shift_flag <= !(err_mode && Opcode == 4'hC);
        end
    end

    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge Clk);
            if (Rsp_Valid === 1'b1 && Rsp_Ready && !Reset) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got id=%0d res=%02h err=%0d", Rsp_Id, Rsp_Result, Rsp_Error);
                end else begin
                    e = sb.pop_front();
                    if ({Rsp_Id, Rsp_Result, Rsp_Error} !== e) begin
                        errors++;
                        $display("FAIL rsp_scoreboard got id=%0d res=%02h err=%0d exp id=%0d res=%02h err=%0d",
                                 Rsp_Id, Rsp_Result, Rsp_Error, e.id, e.res, e.err);
                    end
                end
            end
        end
    endtask

    // Raises valid for every bit in mask and drops each once it is accepted.
    task automatic accept_all(input logic [1:0] mask, output logic [1:0] first_ready);
        logic [1:0] left = mask;
        logic [1:0] grab;
        int n = 0;
        Req_Valid = Req_Valid | mask;
        first_ready = 2'bxx;
        while (left != 2'b00 && n < 40) begin
            @(negedge Clk);
            if (n == 0) first_ready = Req_Ready;
            grab = Req_Ready & left;
            @(posedge Clk); #1;
            Req_Valid = Req_Valid & ~grab;
            left = left & ~grab;
            n++;
        end
        Req_Valid = Req_Valid & ~mask;
        checks++;
        if (left != 2'b00) begin
            errors++;
            $display("FAIL accept_timeout pending=%b required=00", left);
        end
    endtask

    task automatic set_req(input int g, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        Req_Opcode[g] = op;
        Req_A[g] = a;
        Req_B[g] = b;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((sb.size() != 0 || Busy !== 1'b0) && n < 60);
        checks++;
        if (sb.size() != 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%b required 0/0", sb.size(), Busy);
        end
        @(posedge Clk); #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Select !== 3'b000 || Busy !== 1'b0 || Req_Ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl sel=%b busy=%b ready=%b required 000/0/00", Select, Busy, Req_Ready);
        end
        checks++;
        if (Rsp_Valid !== 1'b0 || Rsp_Result !== 8'h00 || Rsp_Error !== 1'b0 || Rsp_Id !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp v=%b res=%02h err=%b id=%b required all zero", Rsp_Valid, Rsp_Result, Rsp_Error, Rsp_Id);
        end
        checks++;
        if (Opcode !== 4'h0 || A !== 8'h00 || B !== 8'h00) begin
            errors++;
            $display("FAIL reset_operands op=%h a=%02h b=%02h required zero", Opcode, A, B);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_gate_and();
        logic [1:0] fr;
        set_req(0, 4'h6, 8'hF0, 8'h3C);
        sb.push_back(mk(1'b0, 8'h30, 1'b0));
        accept_all(2'b01, fr);
        checks++;
        if (fr !== 2'b01) begin errors++; $display("FAIL gate_ready got=%b required=01", fr); end
        @(negedge Clk);
        checks++;
        if (Select !== 3'b010 || Busy !== 1'b1) begin
            errors++; $display("FAIL gate_sel_t1 sel=%b busy=%b required 010/1", Select, Busy);
        end
        @(negedge Clk);
        checks++;
        if (Select !== 3'b010 || Rsp_Valid !== 1'b0) begin
            errors++; $display("FAIL gate_sel_t2 sel=%b rv=%b required 010/0", Select, Rsp_Valid);
        end
        @(negedge Clk);
        checks++;
        if (Rsp_Valid !== 1'b1 || Select !== 3'b000) begin
            errors++; $display("FAIL gate_rsp_t3 rv=%b sel=%b required 1/000", Rsp_Valid, Select);
        end
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] fr;
        pulse_reset();
        for (int rep = 0; rep < 2; rep++) begin
            set_req(0, 4'h8, 8'hAA, 8'h0F);
            set_req(1, 4'h7, 8'h01, 8'h80);
            sb.push_back(mk(1'b0, 8'hA5, 1'b0));
            sb.push_back(mk(1'b1, 8'h81, 1'b0));
            accept_all(2'b11, fr);
            checks++;
            if (fr !== 2'b01) begin errors++; $display("FAIL contention_first rep=%0d got=%b required=01", rep, fr); end
            drain();
        end
        // A lone req0 moves the pointer to req1, which must then win a tie.
        set_req(0, 4'h0, 8'h10, 8'h22);
        sb.push_back(mk(1'b0, 8'h32, 1'b0));
        accept_all(2'b01, fr);
        drain();
        set_req(0, 4'h1, 8'h10, 8'h01);
        set_req(1, 4'h9, 8'hFF, 8'h0F);
        sb.push_back(mk(1'b1, 8'hF0, 1'b0));
        sb.push_back(mk(1'b0, 8'h0F, 1'b0));
        accept_all(2'b11, fr);
        checks++;
        if (fr !== 2'b10) begin errors++; $display("FAIL contention_ptr1 got=%b required=10", fr); end
        drain();
    endtask

    task automatic test_back_pressure();
        logic [1:0] fr;
        int n = 0;
        Rsp_Ready = 1'b0;
        set_req(1, 4'h7, 8'h0F, 8'h30);
        sb.push_back(mk(1'b1, 8'h3F, 1'b0));
        accept_all(2'b10, fr);
        while (Rsp_Valid !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
        checks++;
        if (Rsp_Valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout rv=%b required=1", Rsp_Valid); end
        set_req(0, 4'h8, 8'h55, 8'hFF);
        sb.push_back(mk(1'b0, 8'hAA, 1'b0));
        Req_Valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            checks++;
            if (Rsp_Valid !== 1'b1 || Rsp_Result !== 8'h3F || Rsp_Id !== 1'b1 || Rsp_Error !== 1'b0 ||
                Req_Ready !== 2'b00 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d rv=%b res=%02h id=%b err=%b ready=%b busy=%b required 1/3f/1/0/00/1",
                         c, Rsp_Valid, Rsp_Result, Rsp_Id, Rsp_Error, Req_Ready, Busy);
            end
        end
        @(posedge Clk); #1;
        Rsp_Ready = 1'b1;
        accept_all(2'b01, fr);
        drain();
    endtask

    task automatic test_error();
        logic [1:0] fr;
        err_mode = 1'b1;
        set_req(0, 4'hC, 8'h81, 8'h00);
        sb.push_back(mk(1'b0, 8'h00, 1'b1));
        accept_all(2'b01, fr);
        @(negedge Clk);
        checks++;
        if (Select !== 3'b100) begin errors++; $display("FAIL err_sel got=%b required=100", Select); end
        drain();
        set_req(0, 4'hD, 8'h81, 8'h00);
        sb.push_back(mk(1'b0, 8'h40, 1'b0));
        accept_all(2'b01, fr);
        drain();
        err_mode = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] fr;
        logic seen = 1'b0;
        set_req(0, 4'h0, 8'h03, 8'h04);
        accept_all(2'b01, fr);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Select !== 3'b000 || Busy !== 1'b0 || Rsp_Valid !== 1'b0) begin
            errors++; $display("FAIL midreset_state sel=%b busy=%b rv=%b required 000/0/0", Select, Busy, Rsp_Valid);
        end
        repeat (6) begin @(negedge Clk); if (Rsp_Valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_ghost_rsp seen=1 required=0"); end
        @(posedge Clk); #1;
        set_req(0, 4'h2, 8'h7F, 8'h00);
        set_req(1, 4'hE, 8'h81, 8'h00);
        sb.push_back(mk(1'b0, 8'h80, 1'b0));
        sb.push_back(mk(1'b1, 8'h03, 1'b0));
        accept_all(2'b11, fr);
        checks++;
        if (fr !== 2'b01) begin errors++; $display("FAIL midreset_ptr got=%b required=01", fr); end
        drain();
    endtask

    task automatic test_decode_sweep();
        logic [1:0] fr;
        logic [2:0] es;
        logic [7:0] a, b;
        for (int op = 0; op < 16; op++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            es = (op <= 5) ? 3'b001 : (op <= 11) ? 3'b010 : 3'b100;
            set_req(0, 4'(op), a, b);
            sb.push_back(mk(1'b0, model(4'(op), a, b), 1'b0));
            accept_all(2'b01, fr);
            for (int c = 0; c < 2; c++) begin
                @(negedge Clk);
                checks++;
                if (Select !== es || Opcode !== 4'(op) || A !== a || B !== b) begin
                    errors++;
                    $display("FAIL decode op=%h cyc=%0d sel=%b opc=%h a=%02h b=%02h required %b/%h/%02h/%02h",
                             op, c, Select, Opcode, A, B, es, 4'(op), a, b);
                end
            end
            drain();
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_gate_and();
        test_contention();
        test_back_pressure();
        test_error();
        test_reset_mid_exec();
        test_decode_sweep();
        repeat (2) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
